// File: rtl/md_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and an op-code validity helper.
package md_unit_pkg;

  localparam logic [4:0] MD_MULT  = 5'd0;
  localparam logic [4:0] MD_MULTU = 5'd1;
  localparam logic [4:0] MD_DIV   = 5'd2;
  localparam logic [4:0] MD_DIVU  = 5'd3;
  localparam logic [4:0] MD_MTHI  = 5'd4;
  localparam logic [4:0] MD_MTLO  = 5'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_md_op(input logic [4:0] op);
    return op <= MD_MTLO;
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the multiply/divide datapath. The 2*WIDTH accumulator is
// {upper, lower}. Multiply: LSB-first shift-add, multiplier sits in the lower
// half and is consumed one bit per step. Divide: restoring step, partial
// remainder in the upper half, dividend shifting out of / quotient shifting
// into the lower half.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Compute both candidate steps and pick by operation
  always_comb begin
    sum    = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opb} : '0);
    rem_sh = acc_in[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opb};
    if (is_div) begin
      // diff[WIDTH] is the borrow: set means the divisor did not fit
      if (!diff[WIDTH]) begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Operands are converted to magnitudes on accept, iterated for WIDTH cycles,
// and the sign fix-up is applied in a single FIX cycle before HI/LO update.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             op_invalid,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 4) begin : g_width_chk
    $error("md_unit: WIDTH must be at least 4");
  end

  // Control state
  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  // Datapath state (only meaningful after an accepted MULT/DIV)
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               dbz_pend_q, dbz_pend_d;

  logic signed [WIDTH-1:0] num1_s;
  logic signed [WIDTH-1:0] num2_s;
  logic               accept;
  logic               op_is_div;
  logic               signed_op;
  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] step_acc;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? ((~v) + ONE_W) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? ((~v) + ONE_2W) : v;
  endfunction

  assign num1_s     = num1;
  assign num2_s     = num2;
  assign op_invalid = start & ~is_md_op(op);
  assign accept     = start & is_md_op(op) & (state_q == MD_IDLE);
  assign op_is_div  = (op == MD_DIV) || (op == MD_DIVU);
  assign signed_op  = (op == MD_MULT) || (op == MD_DIV);

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc_in  (acc_q),
    .opb     (opb_q),
    .acc_out (step_acc)
  );

  // Next-state logic: accept, iterate, then sign fix-up and HI/LO write
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    is_div_d   = is_div_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    dbz_pend_d = dbz_pend_q;
    sign1      = 1'b0;
    sign2      = 1'b0;
    mag1       = '0;
    mag2       = '0;
    quo        = '0;
    rem        = '0;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          dbz_d = 1'b0;
          if (op == MD_MTHI) begin
            hi_d = num1;
          end else if (op == MD_MTLO) begin
            lo_d = num1;
          end else begin
            sign1      = signed_op & num1_s[WIDTH-1];
            sign2      = signed_op & num2_s[WIDTH-1];
            mag1       = cond_neg_w(num1, sign1);
            mag2       = cond_neg_w(num2, sign2);
            is_div_d   = op_is_div;
            neg_q_d    = sign1 ^ sign2;
            neg_r_d    = sign1;
            dbz_pend_d = op_is_div && (num2 == '0);
            opb_d      = op_is_div ? mag2 : mag1;
            acc_d      = {{WIDTH{1'b0}}, (op_is_div ? mag1 : mag2)};
            cnt_d      = CNT_W'(WIDTH);
            state_d    = MD_CALC;
            busy_d     = 1'b1;
          end
        end
      end
      MD_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        if (is_div_q) begin
          quo = cond_neg_w(acc_q[WIDTH-1:0], neg_q_q);
          // Remainder follows the dividend's sign; with a zero divisor the
          // restoring loop leaves |num1| here, so this restores num1 itself.
          rem = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_r_q);
          if (dbz_pend_q) begin
            quo   = '1;
            dbz_d = 1'b1;
          end
          lo_d = quo;
          hi_d = rem;
        end else begin
          {hi_d, lo_d} = cond_neg_2w(acc_q, neg_q_q);
        end
      end
      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM and architectural registers, cleared by reset (reset beats start)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Iteration datapath registers, loaded on accept so no reset is needed
  always_ff @(posedge clk) begin
    acc_q      <= acc_d;
    opb_q      <= opb_d;
    is_div_q   <= is_div_d;
    neg_q_q    <= neg_q_d;
    neg_r_q    <= neg_r_d;
    dbz_pend_q <= dbz_pend_d;
  end

  assign busy        = busy_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
